// File: rtl/diff_clock_input_buffer_if.sv
// Port bundle for diff_clock_input_buffer: differential pair in, buffered clock and monitor status out.
// The DUT uses the slave modport; whoever drives the oscillator pair uses master.
interface diff_clock_input_buffer_if #(
  parameter int CNT_W = 16
);
  logic             I;
  logic             IB;
  logic             O;
  logic             diff_fault;
  logic             clk_alive;
  logic [CNT_W-1:0] edge_count;
  logic             window_done;

  modport master (
    output I,
    output IB,
    input  O,
    input  diff_fault,
    input  clk_alive,
    input  edge_count,
    input  window_done
  );

  modport slave (
    input  I,
    input  IB,
    output O,
    output diff_fault,
    output clk_alive,
    output edge_count,
    output window_done
  );
endinterface

// File: rtl/diff_clock_input_buffer.sv
// IBUFGDS-style differential clock input buffer with a clk-domain activity/fault monitor.
// Optional build macro IBUFGDS_DQS_BIAS_EN: an undriven (0,0) pair forces O low instead of holding.
module diff_clock_input_buffer #(
  parameter       DIFF_TERM     = "FALSE",
  parameter       IOSTANDARD    = "DEFAULT",
  parameter int   WINDOW_CYCLES = 1024,
  parameter int   FAULT_CYCLES  = 8,
  parameter int   CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  diff_clock_input_buffer_if.slave bus
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int FLT_W = $clog2(FAULT_CYCLES + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_ARM  = FLT_W'(FAULT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(FAULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // The pad attributes carry no behaviour in this model; folding them here keeps them referenced.
  logic unused_attr;
  assign unused_attr = ^{DIFF_TERM, IOSTANDARD};

  logic o_hold;
  logic o_buf;

  always_latch begin
    if (bus.I ^ bus.IB) begin
      o_hold = bus.I;
    end
`ifdef IBUFGDS_DQS_BIAS_EN
    else if (!bus.I) begin
      o_hold = 1'b0;
    end
`endif
  end

  // The explicit mux, rather than o_hold alone, lets an unknown leg propagate X to O.
`ifdef IBUFGDS_DQS_BIAS_EN
  assign o_buf = (bus.I ^ bus.IB) ? bus.I : (bus.I ? o_hold : 1'b0);
`else
  assign o_buf = (bus.I ^ bus.IB) ? bus.I : o_hold;
`endif

  assign bus.O = o_buf;

  logic [1:0]       o_sync;
  logic [1:0]       i_sync;
  logic [1:0]       ib_sync;
  logic             o_prev;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] edge_count_q;
  logic             window_done_q;
  logic             clk_alive_q;
  logic             diff_fault_q;
  logic [FLT_W-1:0] fault_cnt;

  logic             o_rise;
  logic             pair_invalid;
  logic             win_wrap;
  logic [CNT_W-1:0] acc_next;

  assign o_rise       = o_sync[1] & ~o_prev;
  assign pair_invalid = (i_sync[1] == ib_sync[1]);
  assign win_wrap     = (win_cnt == WIN_LAST);
  assign acc_next     = (o_rise && (acc != CNT_MAX)) ? acc + CNT_W'(1) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_sync  <= '0;
      i_sync  <= '0;
      ib_sync <= '0;
      o_prev  <= 1'b0;
    end else begin
      o_sync  <= {o_sync[0], o_buf};
      i_sync  <= {i_sync[0], bus.I};
      ib_sync <= {ib_sync[0], bus.IB};
      o_prev  <= o_sync[1];
    end
  end

  // acc_next already includes an edge seen on the wrap cycle, so no edge is lost at the boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt       <= '0;
      acc           <= '0;
      edge_count_q  <= '0;
      window_done_q <= 1'b0;
      clk_alive_q   <= 1'b0;
    end else begin
      window_done_q <= win_wrap;
      if (win_wrap) begin
        win_cnt      <= '0;
        acc          <= '0;
        edge_count_q <= acc_next;
        clk_alive_q  <= (acc_next != '0);
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        acc     <= acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cnt    <= '0;
      diff_fault_q <= 1'b0;
    end else if (pair_invalid) begin
      if (fault_cnt == FLT_ARM) begin
        diff_fault_q <= 1'b1;
      end
      if (fault_cnt != FLT_MAX) begin
        fault_cnt <= fault_cnt + FLT_W'(1);
      end
    end else begin
      fault_cnt <= '0;
    end
  end

  assign bus.edge_count  = edge_count_q;
  assign bus.window_done = window_done_q;
  assign bus.clk_alive   = clk_alive_q;
  assign bus.diff_fault  = diff_fault_q;

  a_done_pulse : assert property (@(posedge clk) disable iff (rst)
    window_done_q |=> !window_done_q);

  a_fault_sticky : assert property (@(posedge clk) disable iff (rst)
    diff_fault_q |=> diff_fault_q);

  a_count_only_on_done : assert property (@(posedge clk)
    $changed(edge_count_q) |-> (window_done_q || $past(rst)));

endmodule

// File: tb/tb_diff_clock_input_buffer.sv
// Randomized scoreboard bench for diff_clock_input_buffer: a sample-history model predicts every
// cycle's status outputs and a separate monitor compares them; O is checked against a truth table.
module tb_diff_clock_input_buffer;

  localparam int WINDOW = 100;
  localparam int FAULT  = 8;
  localparam int CW     = 4;
  localparam int MAXE   = 8192;
  localparam int SAT    = (1 << CW) - 1;

  typedef struct packed {
    logic          wd;
    logic          alive;
    logic          fault;
    logic [CW-1:0] ec;
  } status_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic exp_o = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  diff_clock_input_buffer_if #(.CNT_W(CW)) bus ();

  diff_clock_input_buffer #(
    .DIFF_TERM    ("TRUE"),
    .IOSTANDARD   ("LVDS_25"),
    .WINDOW_CYCLES(WINDOW),
    .FAULT_CYCLES (FAULT),
    .CNT_W        (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference history: what every posedge saw on the pair, plus the expected buffered level.
  bit      s_o  [MAXE];
  bit      s_i  [MAXE];
  bit      s_ib [MAXE];
  int      n        = 0;
  int      last_rst = 0;
  status_t exp_q [$];

  function automatic logic buf_model(logic i, logic ib, logic prev);
    if (i != ib) return i;
`ifdef IBUFGDS_DQS_BIAS_EN
    if (!i) return 1'b0;
`endif
    return prev;
  endfunction

  function automatic bit o_at(int m);
    return (m <= last_rst) ? 1'b0 : s_o[m];
  endfunction

  function automatic bit inv_at(int m);
    return (m <= last_rst) ? 1'b1 : (s_i[m] == s_ib[m]);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: actual=0x%0h expected=0x%0h", name, n, actual, expected);
    end
  endtask

  task automatic applyStimulus(logic i, logic ib, logic r);
    @(negedge clk);
    bus.I  = i;
    bus.IB = ib;
    rst    = r;
    exp_o  = buf_model(i, ib, exp_o);
    #1;
    checkOutput("buffer_O", 32'(bus.O), 32'(exp_o));
  endtask

  task automatic drive_square(int half, int cycles);
    logic lvl;
    for (int c = 0; c < cycles; c++) begin
      lvl = ((c / half) % 2 == 0);
      applyStimulus(lvl, !lvl, 1'b0);
    end
  endtask

  // Model: counts sampled rises of O (after the 3-cycle pipeline) per window and scans for
  // FAULT consecutive invalid pair samples, both measured from the most recent reset.
  initial begin : model
    status_t e;
    int      sum;
    bit      all_bad;
    e = '0;
    forever begin
      @(posedge clk);
      if (n >= MAXE) begin
        $display("[TB] FAIL model_capacity: actual=%0d required<%0d", n, MAXE);
        $fatal(1, "[TB] history overflow");
      end
      s_o[n]  = exp_o;
      s_i[n]  = bus.I;
      s_ib[n] = bus.IB;
      e.wd    = 1'b0;
      if (rst) begin
        last_rst = n;
        e        = '0;
      end else begin
        if ((n - last_rst) % WINDOW == 0) begin
          sum = 0;
          for (int k = n - WINDOW + 1; k <= n; k++)
            if (o_at(k - 2) && !o_at(k - 3)) sum++;
          e.wd    = 1'b1;
          e.ec    = CW'((sum > SAT) ? SAT : sum);
          e.alive = (sum != 0);
        end
        if (n - last_rst >= FAULT) begin
          all_bad = 1'b1;
          for (int j = n - FAULT - 1; j <= n - 2; j++)
            if (!inv_at(j)) all_bad = 1'b0;
          if (all_bad) e.fault = 1'b1;
        end
      end
      exp_q.push_back(e);
      n++;
    end
  end

  initial begin : monitor
    status_t act;
    status_t expd;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        expd        = exp_q.pop_front();
        act.wd      = bus.window_done;
        act.alive   = bus.clk_alive;
        act.fault   = bus.diff_fault;
        act.ec      = bus.edge_count;
        checkOutput("status{wd,alive,fault,ec}", 32'(act), 32'(expd));
      end
    end
  end

  initial begin : stimulus
    logic lvl;
    bus.I  = 1'b0;
    bus.IB = 1'b1;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    drive_square(5, 300);
    for (int s = 0; s < 3; s++) drive_square($urandom_range(3, 7), 150);

    lvl = 1'($urandom_range(0, 1));
    repeat (5) applyStimulus(lvl, lvl, 1'b0);
    drive_square($urandom_range(3, 6), 40);

    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);
    drive_square(5, 60);

    repeat (220) applyStimulus(1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 150; c++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    for (int c = 0; c < 2 * WINDOW && ((n - last_rst) % WINDOW) != 50; c++) begin
      lvl = ((c / 4) % 2 == 0);
      applyStimulus(lvl, !lvl, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    drive_square($urandom_range(4, 6), 250);

    drive_square($urandom_range(2, 3), 250);

    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/diff_clock_input_buffer.md
Name: diff_clock_input_buffer

Overview:
- Behavioural model of a global differential clock input buffer (IBUFGDS-equivalent).
- Converts the board oscillator pair (sys_clkp/sys_clkn) into a single-ended clock O that feeds the clock generator's divider chains.
- Adds a small status monitor, clocked by a free-running monitor clock, that reports activity, edge count per window and differential faults on the input pair.

Parameters:
- DIFF_TERM, "FALSE", on-die differential termination attribute; informational only, no behavioural effect.
- IOSTANDARD, "DEFAULT", I/O standard attribute; informational only.
- WINDOW_CYCLES, 1024, monitor window length in clk cycles (>=4).
- FAULT_CYCLES, 8, consecutive clk cycles with I==IB before fault asserts (>=1).
- CNT_W, 16, width of edge_count; saturates at all-ones.

Ports:
- clk  input  1  monitor clock; all registered logic on posedge.
- rst  input  1  synchronous, active-high reset of monitor logic.
- I  input  1  positive leg of differential clock (sys_clkp).
- IB  input  1  negative leg of differential clock (sys_clkn).
- O  output  1  single-ended buffered clock.
- diff_fault  output  1  sticky; I==IB persisted FAULT_CYCLES consecutive clk cycles.
- clk_alive  output  1  last completed window saw at least one rising edge of O.
- edge_count  output  CNT_W  rising edges of O counted in last completed window.
- window_done  output  1  one-cycle pulse when edge_count updates.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Buffer path is combinational and independent of clk/rst:
  - I=1, IB=0 -> O=1.
  - I=0, IB=1 -> O=0.
  - I==IB (both 0 or both 1) -> O holds its last valid value. Power-up value is 0.
  - Either leg X/Z -> O=X (simulation only).
- Zero-delay model; O changes in the same timestep as the inputs.
- Monitor:
  - O passes through a 2-flop synchronizer into the clk domain; a rising edge is detected on synchronized O (s1 & ~s2).
  - I and IB are each 2-flop synchronized; "invalid" = synced I == synced IB.
- Window counter counts 0..WINDOW_CYCLES-1 and wraps. On the wrap cycle:
  - edge_count <= edges accumulated in the window, including an edge detected in the wrap cycle itself.
  - The accumulator restarts at 0.
  - window_done pulses high for 1 cycle.
  - clk_alive <= (accumulated count != 0).
- Accumulator saturates at 2^CNT_W-1; it never wraps.
- Fault counter increments on each invalid cycle and clears on any valid cycle. When it reaches FAULT_CYCLES, diff_fault sets and stays set until rst.
- rst (sync) values: synchronizers 0, window counter 0, accumulator 0, edge_count 0, window_done 0, clk_alive 0, diff_fault 0, fault counter 0.
- rst mid-window discards the partial count; the first window after rst ends WINDOW_CYCLES cycles after rst deasserts.
- rst has priority over a simultaneous window wrap or fault set.
- Latency: an input edge is counted 3 clk cycles after it occurs (2 sync stages + 1 detect). A fault asserts FAULT_CYCLES+2 cycles after the invalid condition begins.
- Input frequency must be < clk/2 for exact counts. Faster inputs alias; this is not a fault.

Optional Feature:
- Macro IBUFGDS_DQS_BIAS_EN.
- Defined: I=0, IB=0 (undriven pair pulled low) forces O=0 instead of holding. I=1, IB=1 still holds.
- Not defined: both equal states hold the last value, as above.
- Monitor behaviour is identical in both builds.

Test Plan:
- Truth table: apply (I,IB) = (1,0),(0,0),(0,1),(1,1),(1,0) -> O = 1,1,0,0,1. With IBUFGDS_DQS_BIAS_EN, the (0,0) step gives O=0.
- Counting: clk 100 MHz, differential 10 MHz on I/IB, WINDOW_CYCLES=100, after rst -> window_done every 100 cycles; edge_count = 10 (±1 on the first window); clk_alive=1.
- Stuck input: hold I=IB=1 for 20 clk cycles, FAULT_CYCLES=8 -> diff_fault rises at cycle 10 and stays 1 after the pair resumes toggling. clk_alive=0 after the next full window with no edges.
- Glitch below threshold: I==IB for 5 cycles, then valid -> diff_fault stays 0; fault counter cleared.
- Reset mid-window: toggle the input, assert rst for 1 cycle at cycle 50 of a window -> all outputs 0 next cycle; next window_done exactly WINDOW_CYCLES cycles after rst deasserts.
- Saturation: CNT_W=4, 20 edges in one window -> edge_count=15.
